// File: rtl/data_mem_responder_if.sv
// Core data-memory port: read strobe, byte-lane write enables, address and both data paths.
// The core side is the master and the memory/MMIO responder is the slave.
interface data_mem_responder_if;
  logic        ram_r;
  logic [3:0]  ram_w;
  logic [31:0] ram_addr;
  logic [31:0] ram_out;
  logic [31:0] ram_in;

  modport master (
    output ram_r, ram_w, ram_addr, ram_out,
    input  ram_in
  );

  modport slave (
    input  ram_r, ram_w, ram_addr, ram_out,
    output ram_in
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus an MMIO page holding a console TX FIFO,
// a 64-bit free-running cycle counter with high-word snapshot, and a sticky halt flag.
module data_mem_responder #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus,
  input  logic                 brk,
  output logic [7:0]           con_data,
  output logic                 con_valid,
  input  logic                 con_ready,
  output logic                 halted,
  output logic                 bus_err
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    REG_CON    = 2'd0,
    REG_CYC_LO = 2'd1,
    REG_CYC_HI = 2'd2,
    REG_HALT   = 2'd3
  } mmio_reg_e;

  // Address decode; RAM wins if a small MMIO_BASE ever overlaps it.
  logic          is_ram;
  logic          is_mmio;
  logic          is_unmapped;
  logic          any_wr;
  mmio_reg_e     reg_sel;
  logic [AW-1:0] word_idx;

  assign is_ram      = bus.ram_addr < RAM_BYTES;
  assign is_mmio     = !is_ram && (bus.ram_addr[31:4] == MMIO_BASE[31:4]);
  assign is_unmapped = !is_ram && !is_mmio;
  assign any_wr      = |bus.ram_w;
  assign reg_sel     = mmio_reg_e'(bus.ram_addr[3:2]);
  assign word_idx    = bus.ram_addr[AW+1:2];

  // Data RAM
  logic [31:0] mem [MEM_WORDS];

  // NOTE: storage arrays carry no reset; clearing them would force flops instead of RAM macros.
  always_ff @(posedge clk) begin
    if (is_ram && !halted) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ram_w[i]) mem[word_idx][8*i +: 8] <= bus.ram_out[8*i +: 8];
      end
    end
  end

  // Console FIFO
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign con_valid = !empty;
  assign con_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
  assign pop       = con_valid && con_ready;
  assign push_req  = is_mmio && (reg_sel == REG_CON) && bus.ram_w[0] && !halted;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.ram_out[7:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // Cycle counter, high-word snapshot, halt and bus-error flags
  logic [63:0] cycle;
  logic [31:0] hi_shadow;
  logic        halt_wr;
  logic        cyc_lo_rd;

  assign halt_wr   = is_mmio && (reg_sel == REG_HALT) && any_wr;
  assign cyc_lo_rd = bus.ram_r && is_mmio && (reg_sel == REG_CYC_LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle     <= '0;
      hi_shadow <= '0;
      halted    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if (!halted)                                 cycle     <= cycle + 64'd1;
      if (cyc_lo_rd)                               hi_shadow <= cycle[63:32];
      if (brk || halt_wr)                          halted    <= 1'b1;
      if (is_unmapped && (bus.ram_r || any_wr))    bus_err   <= 1'b1;
    end
  end

  // Zero-latency read path; a same-cycle write is not visible until after the edge.
  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    bus.ram_in = 32'h0;
    if (bus.ram_r) begin
      if (is_ram) begin
        bus.ram_in = mem[word_idx];
      end else if (is_mmio) begin
        case (reg_sel)
          REG_CON:    bus.ram_in = {29'b0, overflow, full, empty};
          REG_CYC_LO: bus.ram_in = cycle[31:0];
          REG_CYC_HI: bus.ram_in = hi_shadow;
          REG_HALT:   bus.ram_in = {31'b0, halted};
          default:    bus.ram_in = 32'h0;
        endcase
      end
    end
  end

endmodule
